// File: rtl/multiplier.sv
// ============================================================================
//  Module      : multiplier
//  Description : Sequential shift-add unsigned multiplier. Two N-bit operands
//                are captured on an accepted en request and a 2N-bit product
//                is produced one multiplier bit per CALC cycle, announced by a
//                single-cycle done pulse.
//                Optional macro MULTIPLIER_EARLY_EXIT_EN: CALC ends as soon as
//                no set multiplier bits remain (result is unchanged).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier #(
    parameter int N = 21
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] product,
    output logic           done,
    output logic           busy
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] c_last = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [2*N-1:0]  r_acc;
    logic [2*N-1:0]  r_mcand;
    logic [N-1:0]    r_mplier;
    logic [CW-1:0]   r_cnt;

    // Partial-product sum and the multiplier as it will look after this shift
    logic [2*N-1:0]  w_sum;
    logic [N-1:0]    w_mplier_next;
    logic            w_calc_last;

    // Adder and termination condition for the current CALC iteration
    always_comb begin
        w_sum         = r_acc + r_mcand;
        w_mplier_next = r_mplier >> 1;
`ifdef MULTIPLIER_EARLY_EXIT_EN
        // Stop once the bit being consumed now is the last set one
        w_calc_last   = (r_cnt == c_last) || (w_mplier_next == '0);
`else
        w_calc_last   = (r_cnt == c_last);
`endif
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            product  <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (en) begin
                        r_a     <= a;
                        r_b     <= b;
                        busy    <= 1'b1;
                        r_state <= INIT;
                    end
                end
                INIT: begin
                    r_acc    <= '0;
                    r_mcand  <= {{N{1'b0}}, r_a};
                    r_mplier <= r_b;
                    r_cnt    <= '0;
                    r_state  <= CALC;
                end
                CALC: begin
                    if (r_mplier[0]) begin
                        r_acc <= w_sum;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_calc_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    product <= r_acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multiplier.sv
// ============================================================================
//  Module      : tb_multiplier
//  Description : Scoreboard bench for multiplier. Stimulus pushes expected
//                product and completion cycle; a monitor pops on done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiplier;

    localparam int N = 21;

    typedef struct {
        logic [2*N-1:0] prod;
        int             cyc;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           en;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] product;
    logic           done;
    logic           busy;

    int             cyc;
    int             checks;
    int             errors;
    bit             mon_en;
    logic [2*N-1:0] last_product;
    exp_t           q[$];

    multiplier #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .a       (a),
        .b       (b),
        .product (product),
        .done    (done),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Number of CALC cycles the multiplier bits of op_b should take
    function automatic int calc_cycles(logic [N-1:0] op_b);
        int m;
        m = 0;
        for (int i = 0; i < N; i++) begin
            if (op_b[i]) m = i + 1;
        end
`ifdef MULTIPLIER_EARLY_EXIT_EN
        return (m < 1) ? 1 : m;
`else
        return N;
`endif
    endfunction

    // Monitor: pops on every done pulse, checks product stability otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: cycle %0d product %h, no result expected", cyc, product);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (product !== e.prod || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL result: product %h at cycle %0d, expected %h at cycle %0d",
                                 product, cyc, e.prod, e.cyc);
                    end
                end
                last_product = product;
            end else if (product !== last_product) begin
                checks++;
                errors++;
                $display("FAIL product_stable: product %h without done, expected %h", product, last_product);
                last_product = product;
            end
            if (q.size() > 0 && cyc > q[0].cyc) begin
                checks++;
                errors++;
                $display("FAIL timeout: no done by cycle %0d, expected product %h", q[0].cyc, q[0].prod);
                void'(q.pop_front());
            end
        end
    end

    // Wait (bounded) until every expected result has been seen
    task automatic drain();
        for (int k = 0; k < 200 && q.size() > 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    // Issue one request from idle and record its expected outcome
    task automatic issue(input logic [N-1:0] op_a, input logic [N-1:0] op_b,
                         input logic [2*N-1:0] exp_prod);
        exp_t e;
        @(posedge clk);
        #1;
        a  = op_a;
        b  = op_b;
        en = 1'b1;
        e.prod = exp_prod;
        e.cyc  = cyc + calc_cycles(op_b) + 3;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: busy %b after accept, expected 1", busy);
        end
    endtask

    initial begin
        exp_t e1;
        exp_t e2;
        cyc    = 0;
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        en     = 1'b0;
        a      = '0;
        b      = '0;

        // 1: reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        last_product = '0;
        mon_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (product !== '0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: product %h done %b busy %b, expected 0 0 0", product, done, busy);
            end
        end

        // 2: small operands
        issue(21'd3, 21'd5, 42'd15);
        drain();

        // 3: maximum operands, then zero multiplicand
        issue(21'h1FFFFF, 21'h1FFFFF, 42'h3FFFFC00001);
        drain();
        issue(21'd0, 21'h1FFFFF, 42'd0);
        drain();

        // 4: operand change and en while busy, then reset abort and restart
        @(posedge clk);
        #1;
        a  = 21'd7;
        b  = 21'd9;
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        a  = 21'd1;
        b  = 21'd1;
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
            errors++;
            $display("FAIL abort: busy %b done %b product %h, expected 0 0 0", busy, done, product);
        end
        repeat (30) @(negedge clk);
        issue(21'd12, 21'd10, 42'd120);
        drain();

        // 5: en held high, back-to-back operations
        @(posedge clk);
        #1;
        a  = 21'd2;
        b  = 21'd3;
        en = 1'b1;
        e1.prod = 42'd6;
        e1.cyc  = cyc + calc_cycles(21'd3) + 3;
        q.push_back(e1);
        e2.prod = 42'd20;
        e2.cyc  = e1.cyc + 1 + calc_cycles(21'd5) + 2;
        q.push_back(e2);
        @(posedge clk);
        @(negedge clk);
        a = 21'd4;
        b = 21'd5;
        while (cyc < e1.cyc + 1) @(negedge clk);
        en = 1'b0;
        drain();

        // 6: early-exit shaped multipliers (full latency without the macro)
        issue(21'd5, 21'd1, 42'd5);
        drain();
        issue(21'd9, 21'd0, 42'd0);
        drain();
        issue(21'd3, 21'h100000, 42'h300000);
        drain();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d results outstanding, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
